vsmac_sequencer: RTL

- Control stage directly upstream of the vector-scalar MAC array.
- Accepts one packed input-activation vector of ACCUMULATIONS elements per pass over a valid/ready handshake.
- Fetches one weight column (SIZE lanes) per accumulation step from a synchronous weight memory.
- Drives the array's clear, enable, vector `a` and scalar `b` for exactly ACCUMULATIONS consecutive cycles, then holds a result-valid flag until the consumer accepts it.

---
 rtl/vsmac_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/vsmac_sequencer.sv
// Control stage feeding the vector-scalar MAC array: clear, stream ACCUMULATIONS steps, hold result.
// Optional VSMAC_SEQ_PERF_EN adds busy_cycles / pass_count performance counters.
module vsmac_sequencer #(
  parameter int SIZE          = 6,
  parameter int WIDTH         = 8,
  parameter int ACCUMULATIONS = 3,
  parameter int ADDR_WIDTH    = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH*ACCUMULATIONS-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0]          w_base,
  output logic                           w_rd_en,
  output logic [ADDR_WIDTH-1:0]          w_addr,
  input  logic [WIDTH*SIZE-1:0]          w_data,
  output logic                           mac_clear,
  output logic                           mac_enable,
  output logic [WIDTH*SIZE-1:0]          mac_a,
  output logic [WIDTH-1:0]               mac_b,
  output logic                           out_valid,
  input  logic                           out_ready
`ifdef VSMAC_SEQ_PERF_EN
  ,
  output logic [31:0]                    busy_cycles,
  output logic [15:0]                    pass_count
`endif
);

  localparam int CW = (ACCUMULATIONS > 1) ? $clog2(ACCUMULATIONS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACCUMULATIONS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [WIDTH-1:0]      act [ACCUMULATIONS];
  logic [ADDR_WIDTH-1:0] base;
  logic                  hs;

  assign hs = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      base  <= '0;
      for (int k = 0; k < ACCUMULATIONS; k++) begin
        act[k] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (hs) begin
            for (int k = 0; k < ACCUMULATIONS; k++) begin
              act[k] <= in_data[WIDTH*k +: WIDTH];
            end
            base  <= w_base;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded from the registered state so an async reset zeroes them at once.
  always_comb begin
    in_ready   = 1'b0;
    w_rd_en    = 1'b0;
    w_addr     = '0;
    mac_clear  = 1'b0;
    mac_enable = 1'b0;
    mac_a      = '0;
    mac_b      = '0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: in_ready = 1'b1;
      CLEAR: begin
        mac_clear = 1'b1;
        w_rd_en   = 1'b1;
        w_addr    = base;
      end
      RUN: begin
        mac_enable = 1'b1;
        mac_a      = w_data;
        mac_b      = act[cnt];
        if (cnt != LAST) begin
          w_rd_en = 1'b1;
          w_addr  = base + ADDR_WIDTH'(cnt) + ADDR_WIDTH'(1);
        end
      end
      DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

`ifdef VSMAC_SEQ_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cycles <= '0;
      pass_count  <= '0;
    end else begin
      if (state != IDLE && busy_cycles != 32'hFFFF_FFFF) begin
        busy_cycles <= busy_cycles + 32'd1;
      end
      if (state == DONE && out_ready) begin
        pass_count <= pass_count + 16'd1;
      end
    end
  end
`endif

endmodule
